// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer for the frequency counter: clear, count, settle, latch, evaluate,
// with optional auto-ranging of the gate length from the latched count.
module freq_gate_ctrl #(
  parameter int GATE0      = 1000,
  parameter int GATE1      = 10000,
  parameter int GATE2      = 100000,
  parameter int TW         = 17,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 24,
  parameter int HI_TH      = 9000000,
  parameter int LO_TH      = 800000
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic             auto_en,
  input  logic [1:0]       range_sel,
  input  logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_ovf,
  output logic             counter_en,
  output logic             counter_clrn,
  output logic             latch,
  output logic [1:0]       range,
  output logic             busy,
  output logic             over,
  output logic             under
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;
  localparam logic [2:0] S_EVAL   = 3'd5;

  localparam logic [CNT_W-1:0] HI_C = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO_TH);

  logic [2:0]    state_q, state_d;
  logic [1:0]    range_q, range_d;
  logic          over_q, over_d;
  logic          under_q, under_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          counter_en_q, counter_clrn_q, latch_q, busy_q;

  function automatic logic [TW-1:0] gate_len(input logic [1:0] r);
    case (r)
      2'd0:    gate_len = TW'(GATE0);
      2'd1:    gate_len = TW'(GATE1);
      default: gate_len = TW'(GATE2);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    range_d = range_q;
    over_d  = over_q;
    under_d = under_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (!auto_en) range_d = (range_sel == 2'd3) ? 2'd2 : range_sel;
        timer_d = gate_len(range_d) - TW'(1);
        state_d = S_GATE;
      end
      S_GATE: begin
        if (timer_q == '0) begin
          timer_d = TW'(SETTLE_CYC - 1);
          state_d = S_SETTLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) state_d = S_LATCH;
        else               timer_d = timer_q - TW'(1);
      end
      S_LATCH: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        // Overflow wins: a wrapped small count must not read as under-range.
        over_d  = cnt_ovf || (cnt_value >= HI_C);
        under_d = !over_d && (cnt_value < LO_C);
        if (auto_en) begin
          if (over_d && range_q != 2'd0)       range_d = range_q - 2'd1;
          else if (under_d && range_q < 2'd2)  range_d = range_q + 2'd1;
        end
        state_d = start ? S_CLEAR : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q        <= S_IDLE;
      range_q        <= 2'd0;
      over_q         <= 1'b0;
      under_q        <= 1'b0;
      counter_en_q   <= 1'b0;
      counter_clrn_q <= 1'b0;
      latch_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      range_q        <= range_d;
      over_q         <= over_d;
      under_q        <= under_d;
      counter_en_q   <= (state_d == S_GATE);
      counter_clrn_q <= (state_d != S_CLEAR);
      latch_q        <= (state_d == S_LATCH);
      busy_q         <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    timer_q <= timer_d;
  end

  assign counter_en   = counter_en_q;
  assign counter_clrn = counter_clrn_q;
  assign latch        = latch_q;
  assign range        = range_q;
  assign busy         = busy_q;
  assign over         = over_q;
  assign under        = under_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: directed scenarios plus random traffic against a
// measurement-schedule model (cycle offset within the current measurement).
module tb_freq_gate_ctrl;
  localparam int G0 = 4, G1 = 8, G2 = 16, SC = 2, CW = 24, HI = 100, LO = 5;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          start = 1'b0;
  logic          auto_en = 1'b0;
  logic [1:0]    range_sel = 2'd0;
  logic [CW-1:0] cnt_value = '0;
  logic          cnt_ovf = 1'b0;
  logic          counter_en, counter_clrn, latch, busy, over, under;
  logic [1:0]    range;

  freq_gate_ctrl #(
    .GATE0(G0), .GATE1(G1), .GATE2(G2), .TW(5), .SETTLE_CYC(SC),
    .CNT_W(CW), .HI_TH(HI), .LO_TH(LO)
  ) dut (
    .clk(clk), .resetb(resetb), .start(start), .auto_en(auto_en),
    .range_sel(range_sel), .cnt_value(cnt_value), .cnt_ovf(cnt_ovf),
    .counter_en(counter_en), .counter_clrn(counter_clrn), .latch(latch),
    .range(range), .busy(busy), .over(over), .under(under)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: m_off = -1 when idle, else offset of the current cycle within a measurement
  // (0 clear, 1..G gate, then settle, latch at G+SC+1, evaluate at G+SC+2).
  int m_off = -1, m_g = G0, m_rng = 0;
  bit m_ov = 0, m_un = 0;

  function automatic int glen(input int r);
    return (r == 0) ? G0 : (r == 1) ? G1 : G2;
  endfunction

  task automatic model_reset();
    m_off = -1; m_rng = 0; m_ov = 0; m_un = 0;
  endtask

  task automatic model_edge();
    if (!resetb) begin
      model_reset();
    end else if (m_off == -1) begin
      if (start) m_off = 0;
    end else if (m_off == 0) begin
      if (!auto_en) m_rng = (int'(range_sel) == 3) ? 2 : int'(range_sel);
      m_g = glen(m_rng);
      m_off = 1;
    end else if (m_off < m_g + SC + 2) begin
      m_off++;
    end else begin
      m_ov = cnt_ovf || (int'(cnt_value) >= HI);
      m_un = !m_ov && (int'(cnt_value) < LO);
      if (auto_en) begin
        if (m_ov && m_rng > 0)      m_rng--;
        else if (m_un && m_rng < 2) m_rng++;
      end
      m_off = start ? 0 : -1;
    end
  endtask

  task automatic check_outs();
    chk("counter_en",   32'(counter_en),   32'(m_off >= 1 && m_off <= m_g));
    chk("counter_clrn", 32'(counter_clrn), 32'(resetb && m_off != 0));
    chk("latch",        32'(latch),        32'(m_off == m_g + SC + 1));
    chk("busy",         32'(busy),         32'(m_off != -1));
    chk("range",        32'(range),        32'(m_rng));
    chk("over",         32'(over),         32'(m_ov));
    chk("under",        32'(under),        32'(m_un));
  endtask

  int cyc = 0, en_cur = 0, en_len_last = 0, last_en_cyc = -1;
  int last_latch_cyc = -1, latch_gap = 0, latch_period = 0;
  int latch_cnt = 0, en_rises = 0;
  bit prev_en = 0;

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
    if (counter_en) begin
      if (!prev_en) en_rises++;
      en_cur++;
      last_en_cyc = cyc;
    end else if (prev_en) begin
      en_len_last = en_cur;
      en_cur = 0;
    end
    if (latch) begin
      latch_cnt++;
      latch_gap = cyc - last_en_cyc;
      if (last_latch_cyc >= 0) latch_period = cyc - last_latch_cyc;
      last_latch_cyc = cyc;
    end
    prev_en = counter_en;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_en_rise(input string tag);
    int k;
    k = 0;
    while (counter_en && k < 200) begin tick(); k++; end
    while (!counter_en && k < 200) begin tick(); k++; end
    chk(tag, 32'(counter_en), 32'd1);
  endtask

  initial begin
    int lat0, rise0;
    // Reset state
    ticks(2);
    chk("rst_clrn", 32'(counter_clrn), 32'd0);
    resetb = 1'b1;
    tick();
    chk("idle_clrn", 32'(counter_clrn), 32'd1);

    // Manual range 1, continuous run
    range_sel = 2'd1; cnt_value = 24'd50; start = 1'b1;
    ticks(45);
    chk("man_en_width", 32'(en_len_last), 32'd8);
    chk("man_latch_gap", 32'(latch_gap), 32'd3);
    chk("man_period", 32'(latch_period), 32'd13);
    chk("man_range", 32'(range), 32'd1);

    // range_sel=3 clamps to 2
    range_sel = 2'd3;
    ticks(45);
    chk("clamp_range", 32'(range), 32'd2);
    chk("clamp_en_width", 32'(en_len_last), 32'd16);

    // Auto down from range 2 with overflow and a small wrapped count
    auto_en = 1'b1; cnt_ovf = 1'b1; cnt_value = 24'd3;
    ticks(90);
    chk("down_range", 32'(range), 32'd0);
    chk("down_over", 32'(over), 32'd1);
    chk("down_under", 32'(under), 32'd0);

    // Auto up on a tiny count
    cnt_ovf = 1'b0; cnt_value = 24'd2;
    ticks(90);
    chk("up_range", 32'(range), 32'd2);
    chk("up_under", 32'(under), 32'd1);
    chk("up_over", 32'(over), 32'd0);

    // start dropped two cycles into a gate
    wait_en_rise("drop_wait_en");
    tick();
    start = 1'b0;
    lat0 = latch_cnt; rise0 = en_rises;
    ticks(40);
    chk("drop_latches", 32'(latch_cnt - lat0), 32'd1);
    chk("drop_en_rises", 32'(en_rises - rise0), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a gate
    auto_en = 1'b0; range_sel = 2'd1; start = 1'b1;
    wait_en_rise("rst_wait_en");
    ticks(3);
    lat0 = latch_cnt;
    #2 resetb = 1'b0;
    #1;
    model_reset();
    chk("arst_en", 32'(counter_en), 32'd0);
    chk("arst_clrn", 32'(counter_clrn), 32'd0);
    chk("arst_range", 32'(range), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    ticks(2);
    resetb = 1'b1;
    tick();
    chk("restart_clear", 32'(counter_clrn), 32'd0);
    chk("restart_en0", 32'(counter_en), 32'd0);
    tick();
    chk("restart_en1", 32'(counter_en), 32'd1);
    chk("rst_no_latch", 32'(latch_cnt - lat0), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) auto_en = ~auto_en;
      range_sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cnt_value = CW'($urandom_range(0, 4));
        1:       cnt_value = CW'($urandom_range(5, 99));
        2:       cnt_value = CW'($urandom_range(100, 200));
        default: cnt_value = CW'($urandom);
      endcase
      cnt_ovf = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 resetb = 1'b0;
        #1;
        model_reset();
        check_outs();
        tick();
        resetb = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
